// File: rtl/branch_predict_unit_if.sv
// rtl/branch_predict_unit_if.sv - fetch-side lookup and MEM-side training bus for the branch predictor
interface branch_predict_unit_if;
  logic        if_pc_dummy_unused;
  logic [31:0] if_pc;
  logic        if_stall;
  logic        mem_stall;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        bpu_write_en;
  logic [31:0] bpu_predicted_pc;
  logic        bpu_hit;
  logic [31:0] bpu_last_pc;
  logic [31:0] bpu_lookup_cnt;
  logic [31:0] bpu_mispredict_cnt;

  modport master (
    output if_pc, if_stall, mem_stall, upd_valid, upd_pc, upd_taken, upd_target, bpu_write_en,
    input  bpu_predicted_pc, bpu_hit, bpu_last_pc, bpu_lookup_cnt, bpu_mispredict_cnt
  );

  modport slave (
    input  if_pc, if_stall, mem_stall, upd_valid, upd_pc, upd_taken, upd_target, bpu_write_en,
    output bpu_predicted_pc, bpu_hit, bpu_last_pc, bpu_lookup_cnt, bpu_mispredict_cnt
  );
endinterface

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - direct-mapped BTB with 2-bit saturating direction counters
// Lookup is combinational on if_pc; training from MEM lands at the next posedge (no bypass).
module branch_predict_unit #(
  parameter int          IDX_W    = 4,
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic                 clk,
  input  logic                 reset,
  branch_predict_unit_if.slave bus
);
  localparam int NE    = 1 << IDX_W;
  localparam int TAG_W = 32 - IDX_W - 2;

  logic [NE-1:0]    valid_q, valid_d;
  logic [TAG_W-1:0] tag_q    [NE];
  logic [TAG_W-1:0] tag_d    [NE];
  logic [31:0]      target_q [NE];
  logic [31:0]      target_d [NE];
  logic [1:0]       ctr_q    [NE];
  logic [1:0]       ctr_d    [NE];
  logic [31:0]      last_pc_q, last_pc_d;
  logic [31:0]      lookup_cnt_q, lookup_cnt_d;
  logic [31:0]      mispredict_cnt_q, mispredict_cnt_d;

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit;
  logic [31:0]      predicted_pc;
  logic             unused_pc_low_bits;

  assign unused_pc_low_bits = ^bus.upd_pc[1:0];

  assign lk_idx = bus.if_pc[IDX_W+1:2];
  assign lk_tag = bus.if_pc[31:IDX_W+2];
  assign up_idx = bus.upd_pc[IDX_W+1:2];
  assign up_tag = bus.upd_pc[31:IDX_W+2];

  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // Only the strong/weak taken half of the counter redirects fetch.
  assign predicted_pc = (lk_hit && ctr_q[lk_idx][1]) ? target_q[lk_idx] : bus.if_pc + 32'd4;

  assign bus.bpu_predicted_pc   = predicted_pc;
  assign bus.bpu_hit            = lk_hit;
  assign bus.bpu_last_pc        = last_pc_q;
  assign bus.bpu_lookup_cnt     = lookup_cnt_q;
  assign bus.bpu_mispredict_cnt = mispredict_cnt_q;

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (bus.upd_valid && !bus.mem_stall) begin
      if (up_hit) begin
        if (bus.upd_taken) begin
          target_d[up_idx] = bus.upd_target;
          if (ctr_q[up_idx] != 2'b11) ctr_d[up_idx] = ctr_q[up_idx] + 2'd1;
        end else if (ctr_q[up_idx] != 2'b00) begin
          ctr_d[up_idx] = ctr_q[up_idx] - 2'd1;
        end
      end else if (bus.upd_taken) begin
        // A taken miss evicts whatever aliases into this slot.
        valid_d[up_idx]  = 1'b1;
        tag_d[up_idx]    = up_tag;
        target_d[up_idx] = bus.upd_target;
        ctr_d[up_idx]    = 2'b10;
      end
    end
  end

  always_comb begin
    last_pc_d        = bus.if_stall ? last_pc_q : predicted_pc;
    lookup_cnt_d     = bus.if_stall ? lookup_cnt_q : lookup_cnt_q + 32'd1;
    mispredict_cnt_d = (bus.bpu_write_en && !bus.mem_stall) ? mispredict_cnt_q + 32'd1
                                                            : mispredict_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q          <= '0;
      last_pc_q        <= RESET_PC;
      lookup_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
      for (int i = 0; i < NE; i++) ctr_q[i] <= 2'b00;
    end else begin
      valid_q          <= valid_d;
      last_pc_q        <= last_pc_d;
      lookup_cnt_q     <= lookup_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
      for (int i = 0; i < NE; i++) ctr_q[i] <= ctr_d[i];
    end
  end

  // Tag and target are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NE; i++) begin
      tag_q[i]    <= tag_d[i];
      target_q[i] <= target_d[i];
    end
  end
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - directed self-checking bench for branch_predict_unit
module tb_branch_predict_unit;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   exp_lk = 0;

  always #5 clk = ~clk;

  branch_predict_unit_if bus();

  branch_predict_unit #(.IDX_W(4), .RESET_PC(32'h00000000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.if_pc_dummy_unused = 1'b0;

  task automatic tick();
    @(posedge clk);
    if (reset) exp_lk = 0;
    else if (!bus.if_stall) exp_lk++;
    #1;
  endtask

  task automatic train(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    bus.upd_valid = 1'b1; bus.upd_pc = pc; bus.upd_taken = taken; bus.upd_target = tgt;
    tick();
    bus.upd_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.if_pc = 32'h00000040;
    #1;
    checks++; if (bus.bpu_hit !== 1'b0) begin errors++; $display("FAIL reset_hit got %h exp %h", bus.bpu_hit, 1'b0); end
    checks++; if (bus.bpu_predicted_pc !== 32'h00000044) begin errors++; $display("FAIL reset_pred got %h exp %h", bus.bpu_predicted_pc, 32'h00000044); end
    checks++; if (bus.bpu_lookup_cnt !== 32'd0) begin errors++; $display("FAIL reset_lookup_cnt got %0d exp %0d", bus.bpu_lookup_cnt, 0); end
    checks++; if (bus.bpu_mispredict_cnt !== 32'd0) begin errors++; $display("FAIL reset_mis_cnt got %0d exp %0d", bus.bpu_mispredict_cnt, 0); end
    checks++; if (bus.bpu_last_pc !== 32'h00000000) begin errors++; $display("FAIL reset_last_pc got %h exp %h", bus.bpu_last_pc, 32'h0); end
  endtask

  task automatic test_allocate();
    bus.if_pc = 32'h00000300;
    train(32'h00000040, 1'b1, 32'h00000100);
    bus.if_pc = 32'h00000040;
    #1;
    checks++; if (bus.bpu_hit !== 1'b1) begin errors++; $display("FAIL alloc_hit got %h exp %h", bus.bpu_hit, 1'b1); end
    checks++; if (bus.bpu_predicted_pc !== 32'h00000100) begin errors++; $display("FAIL alloc_pred got %h exp %h", bus.bpu_predicted_pc, 32'h00000100); end
  endtask

  task automatic test_counter_walk();
    train(32'h00000040, 1'b0, 32'h0);
    checks++; if (bus.bpu_predicted_pc !== 32'h00000044) begin errors++; $display("FAIL walk_wnt_pred got %h exp %h", bus.bpu_predicted_pc, 32'h00000044); end
    checks++; if (bus.bpu_hit !== 1'b1) begin errors++; $display("FAIL walk_wnt_hit got %h exp %h", bus.bpu_hit, 1'b1); end
    train(32'h00000040, 1'b0, 32'h0);
    train(32'h00000040, 1'b0, 32'h0);
    checks++; if (bus.bpu_predicted_pc !== 32'h00000044) begin errors++; $display("FAIL walk_snt_sat_pred got %h exp %h", bus.bpu_predicted_pc, 32'h00000044); end
    train(32'h00000040, 1'b1, 32'h00000100);
    checks++; if (bus.bpu_predicted_pc !== 32'h00000044) begin errors++; $display("FAIL walk_up_wnt_pred got %h exp %h", bus.bpu_predicted_pc, 32'h00000044); end
    train(32'h00000040, 1'b1, 32'h00000100);
    checks++; if (bus.bpu_predicted_pc !== 32'h00000100) begin errors++; $display("FAIL walk_up_wt_pred got %h exp %h", bus.bpu_predicted_pc, 32'h00000100); end
    train(32'h00000040, 1'b1, 32'h00000100);
    train(32'h00000040, 1'b1, 32'h00000100);
    train(32'h00000040, 1'b0, 32'h0);
    checks++; if (bus.bpu_predicted_pc !== 32'h00000100) begin errors++; $display("FAIL walk_st_sat_pred got %h exp %h", bus.bpu_predicted_pc, 32'h00000100); end
    train(32'h00000040, 1'b1, 32'h00000180);
    checks++; if (bus.bpu_predicted_pc !== 32'h00000180) begin errors++; $display("FAIL walk_target_upd got %h exp %h", bus.bpu_predicted_pc, 32'h00000180); end
  endtask

  task automatic test_alias();
    train(32'h00000080, 1'b1, 32'h00000200);
    bus.if_pc = 32'h00000040; #1;
    checks++; if (bus.bpu_hit !== 1'b0) begin errors++; $display("FAIL alias_old_hit got %h exp %h", bus.bpu_hit, 1'b0); end
    checks++; if (bus.bpu_predicted_pc !== 32'h00000044) begin errors++; $display("FAIL alias_old_pred got %h exp %h", bus.bpu_predicted_pc, 32'h00000044); end
    bus.if_pc = 32'h00000080; #1;
    checks++; if (bus.bpu_predicted_pc !== 32'h00000200) begin errors++; $display("FAIL alias_new_pred got %h exp %h", bus.bpu_predicted_pc, 32'h00000200); end
    train(32'h000000C0, 1'b0, 32'h00000400);
    checks++; if (bus.bpu_predicted_pc !== 32'h00000200) begin errors++; $display("FAIL miss_nt_keep got %h exp %h", bus.bpu_predicted_pc, 32'h00000200); end
    bus.if_pc = 32'h000000C0; #1;
    checks++; if (bus.bpu_hit !== 1'b0) begin errors++; $display("FAIL miss_nt_noalloc got %h exp %h", bus.bpu_hit, 1'b0); end
  endtask

  task automatic test_same_cycle();
    bus.if_pc = 32'h00000040;
    bus.upd_valid = 1'b1; bus.upd_pc = 32'h00000040; bus.upd_taken = 1'b1; bus.upd_target = 32'h00000100;
    #1;
    checks++; if (bus.bpu_predicted_pc !== 32'h00000044) begin errors++; $display("FAIL same_cycle_pred got %h exp %h", bus.bpu_predicted_pc, 32'h00000044); end
    checks++; if (bus.bpu_hit !== 1'b0) begin errors++; $display("FAIL same_cycle_hit got %h exp %h", bus.bpu_hit, 1'b0); end
    tick();
    bus.upd_valid = 1'b0; #1;
    checks++; if (bus.bpu_last_pc !== 32'h00000044) begin errors++; $display("FAIL same_cycle_last_pc got %h exp %h", bus.bpu_last_pc, 32'h00000044); end
    checks++; if (bus.bpu_predicted_pc !== 32'h00000100) begin errors++; $display("FAIL next_cycle_pred got %h exp %h", bus.bpu_predicted_pc, 32'h00000100); end
  endtask

  task automatic test_stalls();
    bus.mem_stall = 1'b1; bus.bpu_write_en = 1'b1;
    train(32'h00000040, 1'b0, 32'h0);
    bus.mem_stall = 1'b0; bus.bpu_write_en = 1'b0; #1;
    checks++; if (bus.bpu_mispredict_cnt !== 32'd0) begin errors++; $display("FAIL mem_stall_mis_cnt got %0d exp %0d", bus.bpu_mispredict_cnt, 0); end
    checks++; if (bus.bpu_predicted_pc !== 32'h00000100) begin errors++; $display("FAIL mem_stall_no_train got %h exp %h", bus.bpu_predicted_pc, 32'h00000100); end
    bus.bpu_write_en = 1'b1;
    tick();
    bus.bpu_write_en = 1'b0; #1;
    checks++; if (bus.bpu_mispredict_cnt !== 32'd1) begin errors++; $display("FAIL mis_cnt_inc got %0d exp %0d", bus.bpu_mispredict_cnt, 1); end
    checks++; if (bus.bpu_lookup_cnt !== exp_lk) begin errors++; $display("FAIL lookup_cnt got %0d exp %0d", bus.bpu_lookup_cnt, exp_lk); end
    bus.if_stall = 1'b1;
    train(32'h00000040, 1'b0, 32'h0);
    checks++; if (bus.bpu_predicted_pc !== 32'h00000044) begin errors++; $display("FAIL if_stall_train got %h exp %h", bus.bpu_predicted_pc, 32'h00000044); end
    checks++; if (bus.bpu_last_pc !== 32'h00000100) begin errors++; $display("FAIL if_stall_last_pc got %h exp %h", bus.bpu_last_pc, 32'h00000100); end
    checks++; if (bus.bpu_lookup_cnt !== exp_lk) begin errors++; $display("FAIL if_stall_lookup_cnt got %0d exp %0d", bus.bpu_lookup_cnt, exp_lk); end
    bus.if_stall = 1'b0;
  endtask

  task automatic test_wrap_and_reset();
    bus.if_pc = 32'hFFFFFFFC; #1;
    checks++; if (bus.bpu_predicted_pc !== 32'h00000000) begin errors++; $display("FAIL wrap_pred got %h exp %h", bus.bpu_predicted_pc, 32'h0); end
    reset = 1'b1; bus.bpu_write_en = 1'b1;
    train(32'h00000100, 1'b1, 32'h00000300);
    reset = 1'b0; bus.bpu_write_en = 1'b0;
    bus.if_pc = 32'h00000100; #1;
    checks++; if (bus.bpu_hit !== 1'b0) begin errors++; $display("FAIL rst_mid_hit got %h exp %h", bus.bpu_hit, 1'b0); end
    checks++; if (bus.bpu_predicted_pc !== 32'h00000104) begin errors++; $display("FAIL rst_mid_pred got %h exp %h", bus.bpu_predicted_pc, 32'h00000104); end
    bus.if_pc = 32'h00000040; #1;
    checks++; if (bus.bpu_predicted_pc !== 32'h00000044) begin errors++; $display("FAIL rst_mid_old_entry got %h exp %h", bus.bpu_predicted_pc, 32'h00000044); end
    checks++; if (bus.bpu_lookup_cnt !== 32'd0) begin errors++; $display("FAIL rst_mid_lookup_cnt got %0d exp %0d", bus.bpu_lookup_cnt, 0); end
    checks++; if (bus.bpu_mispredict_cnt !== 32'd0) begin errors++; $display("FAIL rst_mid_mis_cnt got %0d exp %0d", bus.bpu_mispredict_cnt, 0); end
    checks++; if (bus.bpu_last_pc !== 32'h00000000) begin errors++; $display("FAIL rst_mid_last_pc got %h exp %h", bus.bpu_last_pc, 32'h0); end
    tick();
    checks++; if (bus.bpu_lookup_cnt !== 32'd1) begin errors++; $display("FAIL post_rst_lookup_cnt got %0d exp %0d", bus.bpu_lookup_cnt, 1); end
    checks++; if (bus.bpu_last_pc !== 32'h00000044) begin errors++; $display("FAIL post_rst_last_pc got %h exp %h", bus.bpu_last_pc, 32'h00000044); end
  endtask

  initial begin
    reset = 1'b1;
    bus.if_pc = 32'h0; bus.if_stall = 1'b0; bus.mem_stall = 1'b0;
    bus.upd_valid = 1'b0; bus.upd_pc = 32'h0; bus.upd_taken = 1'b0; bus.upd_target = 32'h0;
    bus.bpu_write_en = 1'b0;
    tick();
    test_reset();
    test_allocate();
    test_counter_walk();
    test_alias();
    test_same_cycle();
    test_stalls();
    test_wrap_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
